// File: rtl/ysyx_25060166_ifu_pkg.sv
// Shared constants and FSM state encoding for the ysyx_25060166 instruction fetch unit.
`default_nettype none

package ysyx_25060166_ifu_pkg;

  localparam int unsigned IFU_WIDTH    = 32;
  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } ifu_state_e;

endpackage

`default_nettype wire

// File: rtl/ysyx_25060166_ifu.sv
// RV32E fetch unit: owns the PC, fetches one word per req/rsp transaction, hands it to IDU.
// Define YSYX_25060166_IFU_PERF_EN to add the perf_fetch_cnt / perf_wait_cnt outputs.
`default_nettype none

module ysyx_25060166_ifu
  import ysyx_25060166_ifu_pkg::*;
#(
  parameter int unsigned      WIDTH    = IFU_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = IFU_RESET_PC
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [WIDTH-1:0] req_addr,
  input  logic             rsp_valid,
  input  logic [WIDTH-1:0] rsp_data,
  input  logic             rsp_err,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_pc,
  output logic             inst_err,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc
`ifdef YSYX_25060166_IFU_PERF_EN
  ,
  output logic [31:0]      perf_fetch_cnt,
  output logic [31:0]      perf_wait_cnt
`endif
);

  ifu_state_e       state;
  logic [WIDTH-1:0] pc;
  logic             drop;
  logic [WIDTH-1:0] target;

  assign target    = redirect_pc & ~WIDTH'(3);
  assign req_valid = (state == S_REQ) && !redirect_valid;
  assign req_addr  = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (redirect_valid) pc <= target;
          state <= S_REQ;
        end
        S_REQ: begin
          if (redirect_valid) begin
            pc <= target;
          end else if (req_ready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect_valid) pc <= target;
          if (rsp_valid) begin
            // A redirect now or earlier makes this word stale.
            if (drop || redirect_valid) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              inst       <= rsp_data;
              inst_pc    <= pc;
              inst_err   <= rsp_err;
              inst_valid <= 1'b1;
              state      <= S_OUT;
            end
          end else if (redirect_valid) begin
            drop <= 1'b1;
          end
        end
        S_OUT: begin
          if (redirect_valid) begin
            pc         <= target;
            inst_valid <= 1'b0;
            state      <= S_REQ;
          end else if (inst_ready) begin
            pc         <= pc + WIDTH'(4);
            inst_valid <= 1'b0;
            state      <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef YSYX_25060166_IFU_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_wait_cnt  <= '0;
    end else begin
      if (inst_valid && inst_ready) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (state == S_WAIT)          perf_wait_cnt  <= perf_wait_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25060166_ifu.sv
// Directed self-checking bench for ysyx_25060166_ifu.
`default_nettype none

module tb_ysyx_25060166_ifu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef YSYX_25060166_IFU_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_wait_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_25060166_ifu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_err      (inst_err),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
`ifdef YSYX_25060166_IFU_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_wait_cnt (perf_wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check_eq("rst_req_valid",  {31'd0, req_valid},  32'd0);
    check_eq("rst_inst",       inst,                32'd0);
    check_eq("rst_inst_pc",    inst_pc,             32'd0);
    check_eq("rst_inst_err",   {31'd0, inst_err},   32'd0);
    #2 rst_n = 1'b1;
    #1 check_eq("idle_req_valid", {31'd0, req_valid}, 32'd0);

    // First fetch
    tick();
    req_ready = 1'b1;
    #1;
    check_eq("t1_req_valid", {31'd0, req_valid}, 32'd1);
    check_eq("t1_req_addr",  req_addr, 32'h8000_0000);
    tick();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0010_0093;
    #1 check_eq("t1_wait_req_valid", {31'd0, req_valid}, 32'd0);
    tick();
    rsp_valid = 1'b0;
    #1;
    check_eq("t1_inst_valid", {31'd0, inst_valid}, 32'd1);
    check_eq("t1_inst",       inst,    32'h0010_0093);
    check_eq("t1_inst_pc",    inst_pc, 32'h8000_0000);
    check_eq("t1_inst_err",   {31'd0, inst_err}, 32'd0);

    // Back-pressure: hold inst_ready low
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp_inst_valid", {31'd0, inst_valid}, 32'd1);
      check_eq("bp_inst",       inst,    32'h0010_0093);
      check_eq("bp_inst_pc",    inst_pc, 32'h8000_0000);
      check_eq("bp_req_valid",  {31'd0, req_valid}, 32'd0);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0; req_ready = 1'b1;
    #1;
    check_eq("t2_inst_valid", {31'd0, inst_valid}, 32'd0);
    check_eq("t2_req_valid",  {31'd0, req_valid},  32'd1);
    check_eq("t2_req_addr",   req_addr, 32'h8000_0004);

    // Redirect while waiting; late response must be dropped
    tick();
    req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    #1 check_eq("t3_wait_req_valid", {31'd0, req_valid}, 32'd0);
    tick();
    rsp_valid = 1'b1; rsp_data = 32'h1234_5678;
    tick();
    rsp_valid = 1'b0;
    #1;
    check_eq("t3_inst_valid", {31'd0, inst_valid}, 32'd0);
    check_eq("t3_req_valid",  {31'd0, req_valid},  32'd1);
    check_eq("t3_req_addr",   req_addr, 32'h8000_0100);
    tick();
    check_eq("t3_inst_valid2", {31'd0, inst_valid}, 32'd0);

    // Fault response
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF; rsp_err = 1'b1;
    tick();
    rsp_valid = 1'b0; rsp_err = 1'b0;
    #1;
    check_eq("t4_inst_valid", {31'd0, inst_valid}, 32'd1);
    check_eq("t4_inst",       inst,    32'hDEAD_BEEF);
    check_eq("t4_inst_err",   {31'd0, inst_err}, 32'd1);
    check_eq("t4_inst_pc",    inst_pc, 32'h8000_0100);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    #1;
    check_eq("t4_req_valid", {31'd0, req_valid}, 32'd1);
    check_eq("t4_req_addr",  req_addr, 32'h8000_0104);

    // Redirect in S_REQ to the top word, then wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; req_ready = 1'b1;
    #1 check_eq("t5_redir_req_valid", {31'd0, req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check_eq("t5_req_valid", {31'd0, req_valid}, 32'd1);
    check_eq("t5_req_addr",  req_addr, 32'hFFFF_FFFC);
    tick();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0000_0013;
    tick();
    rsp_valid = 1'b0;
    #1 check_eq("t5_inst_pc", inst_pc, 32'hFFFF_FFFC);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    #1 check_eq("t5_wrap_addr", req_addr, 32'h0000_0000);

    // Redirect in S_OUT together with inst_ready; misaligned target
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0000_0055;
    tick();
    rsp_valid = 1'b0;
    #1;
    check_eq("t6_inst_valid", {31'd0, inst_valid}, 32'd1);
    check_eq("t6_inst_pc",    inst_pc, 32'h0000_0000);
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0013;
    tick();
    inst_ready = 1'b0; redirect_valid = 1'b0;
    #1;
    check_eq("t6_inst_valid_off", {31'd0, inst_valid}, 32'd0);
    check_eq("t6_req_addr",       req_addr, 32'h8000_0010);

    // Redirect in the same cycle as the response
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0000_0066;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    tick();
    rsp_valid = 1'b0; redirect_valid = 1'b0;
    #1;
    check_eq("t7_inst_valid", {31'd0, inst_valid}, 32'd0);
    check_eq("t7_req_valid",  {31'd0, req_valid},  32'd1);
    check_eq("t7_req_addr",   req_addr, 32'h8000_0200);

    // Reset pulse while in S_OUT
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0000_0077;
    tick();
    rsp_valid = 1'b0;
    #1 check_eq("t8_inst_valid", {31'd0, inst_valid}, 32'd1);
`ifdef YSYX_25060166_IFU_PERF_EN
    check_eq("perf_fetch", perf_fetch_cnt, 32'd4);
    check_eq("perf_wait",  perf_wait_cnt,  32'd9);
`endif
    #1 rst_n = 1'b0;
    #1;
    check_eq("t8_async_inst_valid", {31'd0, inst_valid}, 32'd0);
    check_eq("t8_async_inst",       inst, 32'd0);
    check_eq("t8_async_req_valid",  {31'd0, req_valid}, 32'd0);
`ifdef YSYX_25060166_IFU_PERF_EN
    check_eq("perf_fetch_rst", perf_fetch_cnt, 32'd0);
    check_eq("perf_wait_rst",  perf_wait_cnt,  32'd0);
`endif
    #1 rst_n = 1'b1;
    tick();
    req_ready = 1'b1;
    #1;
    check_eq("t8_req_valid", {31'd0, req_valid}, 32'd1);
    check_eq("t8_req_addr",  req_addr, 32'h8000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
